// File: rtl/fp_stft_pkg.sv
// Shared constants and types for the floating-point STFT framer and 4-point FFT stage.
package fp_stft_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned FFT_N  = 4;
    localparam int unsigned FILL_W = 3;

    localparam logic [FP_W-1:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE       = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_MINUS_ONE = 32'hBF80_0000;

    typedef enum logic {
        PRIME  = 1'b0,
        STEADY = 1'b1
    } framer_state_e;

    // x0 oldest, x3 newest
    typedef struct packed {
        logic [FP_W-1:0] x0;
        logic [FP_W-1:0] x1;
        logic [FP_W-1:0] x2;
        logic [FP_W-1:0] x3;
    } fp_frame_t;

endpackage

// File: rtl/fp_frame_shreg.sv
// 4-deep x 32-bit sample window; shifts toward x0 and loads the newest sample into x3.
module fp_frame_shreg
    import fp_stft_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            shift,
    input  logic [FP_W-1:0] d,
    output fp_frame_t       q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift) begin
            q.x0 <= q.x1;
            q.x1 <= q.x2;
            q.x2 <= q.x3;
            q.x3 <= d;
        end
    end

endmodule

// File: rtl/fp_stft_framer.sv
// Forms overlapping 4-sample frames from a serial FP32 stream and presents them as
// four complex FFT inputs behind a registered valid/ready slot.
module fp_stft_framer
    import fp_stft_pkg::*;
#(
    parameter int unsigned HOP   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  re_x0,
    output logic [FP_W-1:0]  re_x1,
    output logic [FP_W-1:0]  re_x2,
    output logic [FP_W-1:0]  re_x3,
    output logic [FP_W-1:0]  im_x0,
    output logic [FP_W-1:0]  im_x1,
    output logic [FP_W-1:0]  im_x2,
    output logic [FP_W-1:0]  im_x3,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overrun
);

    if (HOP == 0 || HOP > FFT_N) begin : g_hop_check
        $error("fp_stft_framer: HOP must be in 1..4");
    end

    framer_state_e     state, state_next;
    logic [FILL_W-1:0] fill, fill_next;
    logic [FILL_W-1:0] target_c;
    logic              completing_c;
    logic              in_accept_c;
    logic              out_accept_c;
    logic              snapshot_c;
    logic              stall_c;
    logic [2:0]        stall_run;
    fp_frame_t         sr;
    fp_frame_t         frame;

    assign target_c     = (state == PRIME) ? FILL_W'(FFT_N) : FILL_W'(HOP);
    assign completing_c = (fill + FILL_W'(1)) == target_c;
    // Only the sample that would complete a frame waits for the output slot.
    assign in_ready     = !completing_c || !out_valid || out_ready;
    assign in_accept_c  = in_valid && in_ready;
    assign out_accept_c = out_valid && out_ready;
    assign snapshot_c   = in_accept_c && completing_c;
    assign stall_c      = in_valid && !in_ready;

    fp_frame_shreg u_shreg (
        .clk   (clk),
        .rst   (rst),
        .shift (in_accept_c),
        .d     (in_data),
        .q     (sr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIME;
            fill  <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
        end
    end

    always_comb begin
        state_next = state;
        fill_next  = fill;
        if (in_accept_c) begin
            if (completing_c) begin
                fill_next  = '0;
                state_next = STEADY;
            end else begin
                fill_next = fill + FILL_W'(1);
            end
        end
    end

    // Output slot: a snapshot on the same edge as an output accept replaces the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame     <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (snapshot_c) begin
                frame.x0 <= sr.x1;
                frame.x1 <= sr.x2;
                frame.x2 <= sr.x3;
                frame.x3 <= in_data;
            end
            if (snapshot_c) begin
                out_valid <= 1'b1;
            end else if (out_accept_c) begin
                out_valid <= 1'b0;
            end
            if (out_accept_c) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky flag once a stalled sample has waited 8 consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run <= '0;
            overrun   <= 1'b0;
        end else if (stall_c) begin
            if (stall_run == 3'd7) begin
                overrun <= 1'b1;
            end else begin
                stall_run <= stall_run + 3'd1;
            end
        end else begin
            stall_run <= '0;
        end
    end

    assign re_x0 = frame.x0;
    assign re_x1 = frame.x1;
    assign re_x2 = frame.x2;
    assign re_x3 = frame.x3;
    assign im_x0 = FP_ZERO;
    assign im_x1 = FP_ZERO;
    assign im_x2 = FP_ZERO;
    assign im_x3 = FP_ZERO;

endmodule

// File: tb/tb_fp_stft_framer.sv
// Scoreboard bench for fp_stft_framer: three instances (HOP=2, 4, 1) driven by directed vectors.
module tb_fp_stft_framer;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [31:0] F1  = 32'h3F80_0000;
    localparam logic [31:0] F2  = 32'h4000_0000;
    localparam logic [31:0] F3  = 32'h4040_0000;
    localparam logic [31:0] F4  = 32'h4080_0000;
    localparam logic [31:0] F5  = 32'h40A0_0000;
    localparam logic [31:0] F6  = 32'h40C0_0000;
    localparam logic [31:0] F7  = 32'h40E0_0000;
    localparam logic [31:0] F8  = 32'h4100_0000;
    localparam logic [31:0] F9  = 32'h4110_0000;
    localparam logic [31:0] F10 = 32'h4120_0000;
    localparam logic [31:0] F11 = 32'h4130_0000;
    localparam logic [31:0] F12 = 32'h4140_0000;

    typedef struct packed {
        logic [127:0]     re;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid  [NDUT];
    logic [31:0]      in_data   [NDUT];
    logic             in_ready  [NDUT];
    logic             out_valid [NDUT];
    logic             out_ready [NDUT];
    logic [31:0]      re_x0 [NDUT];
    logic [31:0]      re_x1 [NDUT];
    logic [31:0]      re_x2 [NDUT];
    logic [31:0]      re_x3 [NDUT];
    logic [31:0]      im_x0 [NDUT];
    logic [31:0]      im_x1 [NDUT];
    logic [31:0]      im_x2 [NDUT];
    logic [31:0]      im_x3 [NDUT];
    logic [CNT_W-1:0] frame_cnt [NDUT];
    logic             overrun   [NDUT];

    int n_checks;
    int n_errors;
    int exp_cnt [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int unsigned H = (k == 0) ? 2 : ((k == 1) ? 4 : 1);
        exp_t exp_q[$];
        exp_t mon_e;

        fp_stft_framer #(.HOP(H), .CNT_W(CNT_W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[k]),
            .in_data   (in_data[k]),
            .in_ready  (in_ready[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .re_x0     (re_x0[k]),
            .re_x1     (re_x1[k]),
            .re_x2     (re_x2[k]),
            .re_x3     (re_x3[k]),
            .im_x0     (im_x0[k]),
            .im_x1     (im_x1[k]),
            .im_x2     (im_x2[k]),
            .im_x3     (im_x3[k]),
            .frame_cnt (frame_cnt[k]),
            .overrun   (overrun[k])
        );

        // Monitor: every downstream accept must match the oldest expected frame.
        always @(negedge clk) begin
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dut%0d unexpected frame: got %h %h %h %h, expected none",
                             k, re_x0[k], re_x1[k], re_x2[k], re_x3[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("dut%0d frame re", k),
                          {re_x0[k], re_x1[k], re_x2[k], re_x3[k]}, mon_e.re);
                    check($sformatf("dut%0d frame im", k),
                          {im_x0[k], im_x1[k], im_x2[k], im_x3[k]}, 128'h0);
                    check($sformatf("dut%0d frame_cnt at accept", k),
                          128'(frame_cnt[k]), 128'(mon_e.cnt));
                end
            end
        end
    end

    function automatic logic [127:0] re_of(input int k);
        return {re_x0[k], re_x1[k], re_x2[k], re_x3[k]};
    endfunction

    task automatic push_exp(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        e.re  = {a, b, c, d};
        e.cnt = CNT_W'(exp_cnt[k]);
        exp_cnt[k]++;
        case (k)
            0:       g_dut[0].exp_q.push_back(e);
            1:       g_dut[1].exp_q.push_back(e);
            default: g_dut[2].exp_q.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return g_dut[0].exp_q.size();
            1:       return g_dut[1].exp_q.size();
            default: return g_dut[2].exp_q.size();
        endcase
    endfunction

    // Presents one sample and waits (bounded) for its accept; returns at posedge + 1.
    task automatic send(input int k, input logic [31:0] d);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        @(negedge clk);
        while (!in_ready[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready[k]) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d send timeout: in_ready=0 after %0d cycles, expected 1", k, n);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            exp_cnt[k]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int k);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("dut%0d drained", k), 128'(q_size(k)), 128'h0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s dut%0d out_valid", tag, k), 128'(out_valid[k]), 128'h0);
            check($sformatf("%s dut%0d frame_cnt", tag, k), 128'(frame_cnt[k]), 128'h0);
            check($sformatf("%s dut%0d overrun", tag, k), 128'(overrun[k]), 128'h0);
            check($sformatf("%s dut%0d re", tag, k), re_of(k), 128'h0);
            check($sformatf("%s dut%0d im", tag, k),
                  {im_x0[k], im_x1[k], im_x2[k], im_x3[k]}, 128'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
            exp_cnt[k]   = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // HOP=2, free-flowing output
        send(0, F1); send(0, F2); send(0, F3);
        check("hop2 no frame before 4th", 128'(out_valid[0]), 128'h0);
        push_exp(0, F1, F2, F3, F4);
        send(0, F4);
        check("hop2 out_valid 1 cycle after 4th", 128'(out_valid[0]), 128'h1);
        send(0, F5);
        push_exp(0, F3, F4, F5, F6);
        send(0, F6);
        drain(0);
        check("hop2 frame_cnt", 128'(frame_cnt[0]), 128'd2);
        do_reset();

        // HOP=4: no overlap
        push_exp(1, F1, F2, F3, F4);
        send(1, F1); send(1, F2); send(1, F3); send(1, F4);
        send(1, F5); send(1, F6);
        check("hop4 no frame after 6th", 128'(out_valid[1]), 128'h0);
        push_exp(1, F5, F6, F7, F8);
        send(1, F7); send(1, F8);
        drain(1);
        check("hop4 frame_cnt", 128'(frame_cnt[1]), 128'd2);
        do_reset();

        // HOP=2 backpressure: completing sample stalls, then back-to-back replace
        out_ready[0] = 1'b0;
        send(0, F1); send(0, F2); send(0, F3);
        push_exp(0, F1, F2, F3, F4);
        send(0, F4);
        send(0, F5);
        in_valid[0] = 1'b1;
        in_data[0]  = F6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp completing sample stalled", 128'(in_ready[0]), 128'h0);
            check("bp held frame stable", re_of(0), {F1, F2, F3, F4});
        end
        push_exp(0, F3, F4, F5, F6);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp in_ready follows out_ready", 128'(in_ready[0]), 128'h1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("bp no bubble out_valid", 128'(out_valid[0]), 128'h1);
        check("bp new frame present", re_of(0), {F3, F4, F5, F6});
        check("bp frame_cnt after replace", 128'(frame_cnt[0]), 128'd1);
        drain(0);
        check("bp frame_cnt", 128'(frame_cnt[0]), 128'd2);
        check("bp short stall no overrun", 128'(overrun[0]), 128'h0);
        do_reset();

        // HOP=1: one frame per cycle
        send(2, F1); send(2, F2); send(2, F3);
        push_exp(2, F1, F2, F3, F4);
        push_exp(2, F2, F3, F4, F5);
        push_exp(2, F3, F4, F5, F6);
        send(2, F4);
        check("hop1 out_valid", 128'(out_valid[2]), 128'h1);
        send(2, F5);
        check("hop1 frame_cnt step 1", 128'(frame_cnt[2]), 128'd1);
        check("hop1 out_valid sustained", 128'(out_valid[2]), 128'h1);
        send(2, F6);
        check("hop1 frame_cnt step 2", 128'(frame_cnt[2]), 128'd2);
        drain(2);
        check("hop1 frame_cnt", 128'(frame_cnt[2]), 128'd3);

        // Reset mid-frame (dut2 still holds a nonzero window and count)
        send(0, F1); send(0, F2); send(0, F3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) exp_cnt[k] = 0;
        @(negedge clk);
        check_all_zero("mid reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, F9); send(0, F10); send(0, F11);
        check("post reset needs 4 fresh", 128'(out_valid[0]), 128'h0);
        push_exp(0, F9, F10, F11, F12);
        send(0, F12);
        drain(0);
        check("post reset frame_cnt", 128'(frame_cnt[0]), 128'd1);
        do_reset();

        // Bit transparency and overrun on HOP=4
        out_ready[1] = 1'b0;
        push_exp(1, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001);
        send(1, 32'h7FC0_0000); send(1, 32'hFF80_0000);
        send(1, 32'h8000_0000); send(1, 32'h0000_0001);
        check("special values bit-exact", re_of(1),
              {32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001});
        send(1, F1); send(1, F2); send(1, F3);
        in_valid[1] = 1'b1;
        in_data[1]  = F4;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("overrun clear after 7 stalls", 128'(overrun[1]), 128'h0);
        @(posedge clk);
        @(negedge clk);
        check("overrun set after 8 stalls", 128'(overrun[1]), 128'h1);
        repeat (3) @(posedge clk);
        push_exp(1, F1, F2, F3, F4);
        #1;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        drain(1);
        check("overrun sticky", 128'(overrun[1]), 128'h1);
        check("special frame_cnt", 128'(frame_cnt[1]), 128'd2);
        do_reset();
        @(negedge clk);
        check("overrun cleared by rst", 128'(overrun[1]), 128'h0);

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d final queue empty", k), 128'(q_size(k)), 128'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_stft_framer.md
Name: fp_stft_framer

Overview:
- Upstream neighbour of the 4-point floating-point FFT stage.
- Accepts a serial stream of IEEE-754 single-precision real samples with a valid/ready handshake.
- Forms overlapping 4-sample frames with a configurable hop and presents each frame in parallel as four complex inputs (imaginary = +0.0), with a registered valid/ready output handshake.
- out_valid drives the FFT's valid_in, and re_x0..re_x3 / im_x0..im_x3 connect one-to-one.

Parameters:
- HOP, 2, new samples between successive frames; legal range 1..4. Any other value is an elaboration error: 4 gives no overlap, 1 gives maximum overlap.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_data  in  32  real sample, IEEE-754 single
- in_ready  out  1  block can accept in_data this cycle
- out_valid  out  1  frame on re_x*/im_x* is valid
- out_ready  in  1  downstream accepts frame this cycle
- re_x0..re_x3  out  32 each  frame samples; x0 oldest, x3 newest
- im_x0..im_x3  out  32 each  constant 32'h00000000
- frame_cnt  out  CNT_W  frames accepted downstream, wraps modulo 2^CNT_W
- overrun  out  1  sticky; set if in_valid is high while in_ready is low for 8 or more consecutive cycles; cleared only by rst

Behaviour:
- Reset (async assert, sync release). All of the following are zero: shift register, output registers, out_valid, frame_cnt, overrun. The fill counter is cleared and the FSM goes to PRIME. im_x* are always 0.
- Transfer rules:
  - Input accept: in_valid && in_ready.
  - Output accept: out_valid && out_ready.
  - The data path is fully registered; only in_ready may depend combinationally on out_ready.
- Shift register:
  - On each input accept, sr <= {sr[1..3], in_data}; sr[3] is newest.
  - Sample bits pass through untouched, including NaN, Inf, denormals and -0.0. No arithmetic is performed.
- FSM:
  - PRIME: target = 4 accepted samples. Moves to STEADY when the 4th is accepted.
  - STEADY: target = HOP accepted samples.
- Fill counter: counts accepts since the last snapshot (PRIME from reset). "Completing accept" = an accept that makes the counter equal the current target.
- Snapshot on a completing accept:
  - Output regs load the post-shift window, i.e. the 3 previous samples plus in_data.
  - out_valid goes high on the next edge. Latency from completing sample to out_valid is 1 cycle.
  - The fill counter resets to 0.
- Output slot:
  - out_valid stays high and re_x* stay stable until the output accept.
  - On an output accept with no simultaneous snapshot, out_valid falls and frame_cnt increments.
- Backpressure: in_ready = !(next accept would complete) || !out_valid || out_ready.
  - Non-completing samples are always accepted, even while a frame is held.
  - Only the completing sample stalls until the slot frees.
- Simultaneous output accept and snapshot (the same edge): the new frame replaces the old one, out_valid stays 1 and frame_cnt increments. This gives back-to-back frames with no bubble.
- HOP=1 in STEADY: every accept completes, so sustained throughput is 1 frame per cycle when out_ready=1.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-frame: the partial window is discarded. The first frame after reset again needs 4 fresh samples.

Decomposition:
- Shared package fp_stft_pkg holds:
  - FP_ZERO = 32'h00000000, FP_ONE = 32'h3F800000, FP_MINUS_ONE = 32'hBF800000 (also used by the FFT twiddles).
  - FFT_N = 4.
  - Framer FSM state enum {PRIME, STEADY}.
- One natural sub-module: fp_frame_shreg, a 4-deep x 32-bit shift register with shift enable, async reset and parallel outputs. The framer owns the FSM, counters, output regs and handshake.

Test Plan:
- HOP=2, out_ready=1; stream 1.0, 2.0, 3.0, 4.0, 5.0, 6.0 (3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000) -> frame {1,2,3,4} one cycle after the 4th accept, then {3,4,5,6}; im_x*=0; frame_cnt=2.
- HOP=4, same stream plus 7.0, 8.0 -> frames {1,2,3,4} and {5,6,7,8} only; no frame after the 6th sample.
- HOP=2, out_ready=0 after the first frame; stream 5.0, 6.0 -> 5.0 is accepted and 6.0 is stalled (in_ready=0) while re_x* holds {1,2,3,4}. Raise out_ready -> 6.0 is accepted on that edge and {3,4,5,6} is presented next cycle with no bubble.
- HOP=1, out_ready=1, continuous stream 1..6 -> frames {1,2,3,4}, {2,3,4,5}, {3,4,5,6} on consecutive cycles; frame_cnt increments each cycle.
- Assert rst after 3 samples; then stream 9.0, 10.0, 11.0, 12.0 -> all outputs are 0 during reset; the first frame is {9,10,11,12} with frame_cnt=0 before its accept.
- Bit transparency: stream 7FC00000, FF800000, 80000000, 00000001 with HOP=4 -> the frame reproduces these values bit-exact; hold out_ready=0 with in_valid=1 for 8 or more cycles -> overrun=1 and stays set until rst.
